// File: rtl/noc_flit_receiver.sv
// Node-side NoC receive interface: checks destination, strips the head flit and
// delivers framed payload beats through a 2-entry output buffer, counting errors.
module noc_flit_receiver #(
  parameter logic [1:0]  NODE_ID = 2'd0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      data_in,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [61:0]      out_data,
  output logic [1:0]       out_src,
  output logic             out_first,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_misroute_cnt,
  output logic [CNT_W-1:0] err_proto_cnt
);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  src_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;

  logic        accept, is_head, is_single, is_tail, dest_ok;
  logic        push, push_first, push_last;
  logic [61:0] push_data;
  logic [1:0]  push_src;
  logic        load_hdr, cnt_inc, misroute_inc, proto_inc;

  logic [61:0] mem_data  [2];
  logic [1:0]  mem_src   [2];
  logic        mem_first [2];
  logic        mem_last  [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  occ_q;
  logic        pop;

  assign ready_in  = !rst && (occ_q != 2'd2);
  assign accept    = valid_in && ready_in;
  assign is_head   = (data_in[63:62] == 2'b01);
  assign is_single = (data_in[63:62] == 2'b11);
  assign is_tail   = (data_in[63:62] == 2'b10);
  assign dest_ok   = (data_in[61:60] == NODE_ID);

  always_comb begin
    state_d      = state_q;
    push         = 1'b0;
    push_first   = 1'b0;
    push_last    = 1'b0;
    push_data    = data_in[61:0];
    push_src     = src_q;
    load_hdr     = 1'b0;
    cnt_inc      = 1'b0;
    misroute_inc = 1'b0;
    proto_inc    = 1'b0;
    if (accept) begin
      if (is_head || is_single) begin
        // A header outside IDLE abandons the open packet, then is handled as in IDLE.
        if (state_q != IDLE) proto_inc = 1'b1;
        if (!dest_ok) begin
          misroute_inc = 1'b1;
          state_d      = is_head ? DROP : IDLE;
        end else if (is_head) begin
          load_hdr = 1'b1;
          state_d  = RECV;
        end else begin
          push       = 1'b1;
          push_first = 1'b1;
          push_last  = 1'b1;
          push_data  = {4'b0000, data_in[57:0]};
          push_src   = data_in[59:58];
          state_d    = IDLE;
        end
      end else begin
        case (state_q)
          RECV: begin
            push       = 1'b1;
            push_first = (cnt_q == 8'd0);
            if (is_tail) begin
              push_last = 1'b1;
              state_d   = IDLE;
              if (cnt_q != len_q - 8'd1) proto_inc = 1'b1;
            end else begin
              cnt_inc = 1'b1;
              if (cnt_q >= len_q - 8'd1) proto_inc = 1'b1;
            end
          end
          DROP: if (is_tail) state_d = IDLE;
          default: proto_inc = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      src_q            <= '0;
      len_q            <= '0;
      cnt_q            <= '0;
      err_misroute_cnt <= '0;
      err_proto_cnt    <= '0;
    end else begin
      state_q <= state_d;
      if (load_hdr) begin
        src_q <= data_in[59:58];
        len_q <= data_in[57:50];
        cnt_q <= '0;
      end else if (cnt_inc && cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (misroute_inc && err_misroute_cnt != '1)
        err_misroute_cnt <= err_misroute_cnt + CNT_W'(1);
      if (proto_inc && err_proto_cnt != '1)
        err_proto_cnt <= err_proto_cnt + CNT_W'(1);
    end
  end

  assign pop       = (occ_q != 2'd0) && out_ready;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = mem_data[rd_ptr];
  assign out_src   = mem_src[rd_ptr];
  assign out_first = mem_first[rd_ptr];
  assign out_last  = mem_last[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ_q  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_data[i]  <= '0;
        mem_src[i]   <= '0;
        mem_first[i] <= 1'b0;
        mem_last[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr]  <= push_data;
        mem_src[wr_ptr]   <= push_src;
        mem_first[wr_ptr] <= push_first;
        mem_last[wr_ptr]  <= push_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      occ_q <= occ_q + 2'd1;
      else if (pop && !push) occ_q <= occ_q - 2'd1;
    end
  end

endmodule

// File: tb/tb_noc_flit_receiver.sv
// Directed self-checking bench for noc_flit_receiver (NODE_ID 0, 2-bit counters).
module tb_noc_flit_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [61:0] out_data;
  logic [1:0]  out_src;
  logic        out_first, out_last, out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  err_misroute_cnt, err_proto_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [65:0] cap[$];

  noc_flit_receiver #(.NODE_ID(2'd0), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .out_data(out_data), .out_src(out_src), .out_first(out_first), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .err_misroute_cnt(err_misroute_cnt), .err_proto_cnt(err_proto_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    if (out_valid && out_ready) cap.push_back({out_data, out_src, out_first, out_last});
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] f);
    int unsigned n = 0;
    data_in  = f;
    valid_in = 1'b1;
    while (!ready_in && n < 20) begin
      step();
      n++;
    end
    check("send_ready", 66'(ready_in), 66'd1);
    if (ready_in) step();
    valid_in = 1'b0;
  endtask

  task automatic check_beat(input string tag, input int unsigned idx, input logic [61:0] d,
                            input logic [1:0] s, input logic f, input logic l);
    if (idx < cap.size()) check(tag, cap[idx], {d, s, f, l});
    else check(tag, 66'(cap.size()), 66'(idx + 1));
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [63:0] head(input logic [1:0] d, input logic [1:0] s, input logic [7:0] len);
    return {2'b01, d, s, len, 50'd0};
  endfunction
  function automatic logic [63:0] single(input logic [1:0] d, input logic [1:0] s, input logic [57:0] p);
    return {2'b11, d, s, p};
  endfunction
  function automatic logic [63:0] body(input logic [61:0] p);
    return {2'b00, p};
  endfunction
  function automatic logic [63:0] tail(input logic [61:0] p);
    return {2'b10, p};
  endfunction

  initial begin
    // reset state
    #2;
    check("rst_ready",    66'(ready_in),         66'd0);
    check("rst_valid",    66'(out_valid),        66'd0);
    check("rst_firstlast",66'({out_first, out_last}), 66'd0);
    check("rst_data",     66'({out_data, out_src}),   66'd0);
    check("rst_cnts",     66'({err_misroute_cnt, err_proto_cnt}), 66'd0);
    apply_reset();
    check("rel_ready",    66'(ready_in),         66'd1);

    // well-formed 3-beat packet, back to back
    out_ready = 1'b1;
    cap.delete();
    send(head(2'd0, 2'd3, 8'd3));
    check("t1_head_novalid", 66'(out_valid), 66'd0);
    send(body(62'h1111_2222_3333_4444));
    check("t1_a", {out_valid, out_data, out_src, out_first, out_last},
          {1'b1, 62'h1111_2222_3333_4444, 2'd3, 1'b1, 1'b0});
    send(body(62'h0555_6666_7777_8888));
    check("t1_b", {out_valid, out_data, out_src, out_first, out_last},
          {1'b1, 62'h0555_6666_7777_8888, 2'd3, 1'b0, 1'b0});
    send(tail(62'h2999_AAAA_BBBB_CCCC));
    check("t1_c", {out_valid, out_data, out_src, out_first, out_last},
          {1'b1, 62'h2999_AAAA_BBBB_CCCC, 2'd3, 1'b0, 1'b1});
    step();
    check("t1_drained", 66'(out_valid), 66'd0);
    check("t1_ncap", 66'(cap.size()), 66'd3);
    check("t1_cnts", 66'({err_misroute_cnt, err_proto_cnt}), 66'd0);

    // misrouted packet is swallowed
    send(head(2'd2, 2'd1, 8'd3));
    send(body(62'h1));
    send(body(62'h2));
    check("t2_mid_novalid", 66'(out_valid), 66'd0);
    send(tail(62'h3));
    check("t2_novalid", 66'(out_valid), 66'd0);
    check("t2_misroute", 66'(err_misroute_cnt), 66'd1);
    check("t2_proto", 66'(err_proto_cnt), 66'd0);

    // stray TAIL, then a HEAD abandoning an open packet
    cap.delete();
    send(tail(62'h7));
    check("t3_stray_tail", 66'(err_proto_cnt), 66'd1);
    send(head(2'd0, 2'd1, 8'd2));
    send(head(2'd0, 2'd2, 8'd1));
    check("t3_reheader", 66'(err_proto_cnt), 66'd2);
    send(tail(62'h0123_4567_89AB_CDEF));
    check("t3_beat", {out_valid, out_data, out_src, out_first, out_last},
          {1'b1, 62'h0123_4567_89AB_CDEF, 2'd2, 1'b1, 1'b1});
    step();
    check("t3_ncap", 66'(cap.size()), 66'd1);
    check("t3_proto_final", 66'(err_proto_cnt), 66'd2);

    // backpressure: only two flits fit, then everything drains in order
    out_ready = 1'b0;
    cap.delete();
    send(single(2'd0, 2'd1, 58'h000_0000_0000_00A0));
    check("t4_rdy_after1", 66'(ready_in), 66'd1);
    send(single(2'd0, 2'd1, 58'h000_0000_0000_00A1));
    check("t4_rdy_full", 66'(ready_in), 66'd0);
    data_in  = single(2'd0, 2'd1, 58'h000_0000_0000_00A2);
    valid_in = 1'b1;
    step();
    step();
    check("t4_still_full", 66'(ready_in), 66'd0);
    check("t4_hold", {out_valid, out_data}, {1'b1, 62'h0A0});
    out_ready = 1'b1;
    step();
    check("t4_rdy_after_pop", 66'(ready_in), 66'd1);
    check("t4_head_next", 66'(out_data), 66'h0A1);
    send(single(2'd0, 2'd1, 58'h000_0000_0000_00A2));
    send(single(2'd0, 2'd1, 58'h000_0000_0000_00A3));
    for (int i = 0; i < 3; i++) step();
    check("t4_ncap", 66'(cap.size()), 66'd4);
    for (int unsigned i = 0; i < 4; i++)
      check_beat("t4_beat", i, 62'h0A0 + 62'(i), 2'd1, 1'b1, 1'b1);

    // over-long packet, counter saturation at 3
    apply_reset();
    check("t5_rst_cnts", 66'({err_misroute_cnt, err_proto_cnt}), 66'd0);
    cap.delete();
    send(head(2'd0, 2'd1, 8'd2));
    send(body(62'hD0));
    check("t5_body1", 66'(err_proto_cnt), 66'd0);
    send(body(62'hD1));
    check("t5_body2", 66'(err_proto_cnt), 66'd1);
    send(body(62'hD2));
    check("t5_body3", 66'(err_proto_cnt), 66'd2);
    send(tail(62'hD3));
    check("t5_tail", 66'(err_proto_cnt), 66'd3);
    send(tail(62'hD4));
    check("t5_saturate", 66'(err_proto_cnt), 66'd3);
    step();
    check("t5_ncap", 66'(cap.size()), 66'd4);
    check_beat("t5_b0", 0, 62'hD0, 2'd1, 1'b1, 1'b0);
    check_beat("t5_b1", 1, 62'hD1, 2'd1, 1'b0, 1'b0);
    check_beat("t5_b2", 2, 62'hD2, 2'd1, 1'b0, 1'b0);
    check_beat("t5_b3", 3, 62'hD3, 2'd1, 1'b0, 1'b1);

    // reset mid-packet with a buffered beat
    out_ready = 1'b0;
    send(head(2'd0, 2'd2, 8'd3));
    send(body(62'hE0));
    check("t6_buffered", 66'(out_valid), 66'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 66'(out_valid), 66'd0);
    check("t6_rst_ready", 66'(ready_in), 66'd0);
    check("t6_rst_cnt", 66'(err_proto_cnt), 66'd0);
    step();
    rst = 1'b0;
    #1;
    check("t6_rel_ready", 66'(ready_in), 66'd1);
    out_ready = 1'b1;
    send(single(2'd0, 2'd3, 58'h1AB_CDEF_0123_4567));
    check("t6_single", {out_valid, out_data, out_src, out_first, out_last},
          {1'b1, 4'b0000, 58'h1AB_CDEF_0123_4567, 2'd3, 1'b1, 1'b1});
    check("t6_cnts", 66'({err_misroute_cnt, err_proto_cnt}), 66'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
